ram_dp_arbiter: RTL
===================

RAM_DP_ARBITER -- requirements
Module: ram_dp_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, 32, number of RAM words.
REQ-002 SHALL have parameter WIDTH, 8, data bits per word.
REQ-003 SHALL have parameter AWIDTH, $clog2(DEPTH), address bits.
REQ-004 SHALL have port clk  input  1  single clock; drives the arbiter, and both RAM clocks (wclk, rclk) are tied to it.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port wr_valid  input  [1:0]  write request per requester.
REQ-007 SHALL have port wr_addr  input  [1:0][AWIDTH-1:0]  write address per requester.
REQ-008 SHALL have port wr_data  input  [1:0][WIDTH-1:0]  write data per requester.
REQ-009 SHALL have port wr_ready  output  [1:0]  write grant per requester.
REQ-010 SHALL have port rd_valid  input  [1:0]  read request per requester.
REQ-011 SHALL have port rd_addr  input  [1:0][AWIDTH-1:0]  read address per requester.
REQ-012 SHALL have port rd_ready  output  [1:0]  read grant per requester.
REQ-013 SHALL have port rd_rvalid  output  [1:0]  read data valid, one-hot to the owning requester.
REQ-014 SHALL have port rd_rdata  output  [WIDTH-1:0]  read data, shared by both requesters.
REQ-015 SHALL have ports ram_wenable/ram_waddr/ram_wdata  output  1/AWIDTH/WIDTH  to the RAM write port.
REQ-016 SHALL have ports ram_renable/ram_raddr  output  1/AWIDTH  to the RAM read port; ram_rdata  input  WIDTH, registered RAM read data.
REQ-017 SHALL have port stall_count  output  16  number of collision-stalled read cycles.

Function
REQ-018 A transfer SHALL occur on a clk edge where valid[i] && ready[i]; at most one write and one read SHALL transfer per cycle.
REQ-019 wr_ready/rd_ready SHALL be combinational from the valids, addresses and priority registers; ready SHALL never assert without the matching valid.
REQ-020 Each port SHALL keep a 1-bit round-robin pointer (wr_pri, rd_pri): a single eligible requester is granted; two eligible requesters resolve to the one equal to the pointer.
REQ-021 After a transfer by requester i, that port's pointer SHALL become 1-i; with no transfer it SHALL hold.
REQ-022 An accepted write SHALL drive ram_wenable=1, ram_waddr, ram_wdata from registers during the next cycle only.
REQ-023 An accepted read SHALL drive ram_renable=1 and ram_raddr during the next cycle; rd_rvalid[i]=1 and rd_rdata=ram_rdata SHALL appear exactly 2 cycles after the accepting edge, for one cycle.
REQ-024 Collision: a read requester whose rd_addr equals the address of the write transferring in the same cycle SHALL be ineligible that cycle (write wins; the read returns the new data later).
REQ-025 A collision-ineligible requester SHALL NOT block the other read requester, which remains grantable.
REQ-026 stall_count SHALL increment by 1 in each cycle where at least one read requester is blocked only by REQ-024, and SHALL saturate at 16'hFFFF.
REQ-027 Reads and writes SHALL be fully pipelined: back-to-back transfers every cycle, no bubbles except those from REQ-024.
REQ-028 With no transfer, ram_wenable and ram_renable SHALL be 0 in the following cycle; the address and data registers SHALL hold.

Reset
REQ-029 While rst_n=0 at an edge: wr_pri=rd_pri=0, ram_wenable=0, ram_renable=0, ram_waddr=ram_raddr=0, ram_wdata=0, rd_rvalid=0, rd_rdata=0, stall_count=0.
REQ-030 Reads or writes in flight at reset SHALL be discarded: no rd_rvalid after reset, and no RAM enable in the cycle after reset.
REQ-031 wr_ready and rd_ready SHALL be 0 while rst_n=0.

Verification
REQ-032 Single write requester 0 writes addr 5 = 8'hA5, then reader 1 reads addr 5 -> ram_wenable 1 cycle after the grant; rd_rvalid=2'b10, rd_rdata=8'hA5 two cycles after the read grant.
REQ-033 Both writers valid for 4 cycles after reset -> grants 0,1,0,1; all four writes reach the RAM in order.
REQ-034 Writer 0 to addr 3 and reader 0 from addr 3 in the same cycle, old value 8'h11, new value 8'h22 -> read stalls 1 cycle, returns 8'h22, stall_count=1.
REQ-035 Reader 0 collides on addr 7 while reader 1 requests addr 9 in the same cycle -> reader 1 granted that cycle; reader 0 granted the next cycle.
REQ-036 rst_n=0 one cycle after a read grant -> no rd_rvalid; all outputs at reset values; first post-reset grant goes to requester 0 when both are valid.
REQ-037 Random traffic from 4 requesters over 3*DEPTH cycles -> every read matches the mirror memory, and no RAM enable occurs without a preceding grant.

Source files
------------

// File: rtl/ram_dp_arbiter.sv
// ram_dp_arbiter
// Two-requester round-robin arbiter in front of a simple dual-port RAM
// (one write port, one registered-read port, both clocked by clk).
//
// Ports:
//   clk, rst_n                      single clock, synchronous active-low reset
//   wr_valid/wr_addr/wr_data [1:0]  write requests, wr_ready [1:0] grants
//   rd_valid/rd_addr [1:0]          read requests, rd_ready [1:0] grants
//   rd_rvalid [1:0], rd_rdata       read return, one-hot to the owner,
//                                   two cycles after the accepting edge
//   ram_wenable/ram_waddr/ram_wdata registered RAM write port drive
//   ram_renable/ram_raddr           registered RAM read port drive
//   ram_rdata                       registered RAM read data
//   stall_count                     saturating count of read-collision cycles
module ram_dp_arbiter #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 8,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             wr_valid,
  input  logic [1:0][AWIDTH-1:0] wr_addr,
  input  logic [1:0][WIDTH-1:0]  wr_data,
  output logic [1:0]             wr_ready,
  input  logic [1:0]             rd_valid,
  input  logic [1:0][AWIDTH-1:0] rd_addr,
  output logic [1:0]             rd_ready,
  output logic [1:0]             rd_rvalid,
  output logic [WIDTH-1:0]       rd_rdata,
  output logic                   ram_wenable,
  output logic [AWIDTH-1:0]      ram_waddr,
  output logic [WIDTH-1:0]       ram_wdata,
  output logic                   ram_renable,
  output logic [AWIDTH-1:0]      ram_raddr,
  input  logic [WIDTH-1:0]       ram_rdata,
  output logic [15:0]            stall_count
);

  // Round-robin pick between two requesters: a lone requester wins,
  // a tie goes to the requester equal to the pointer.
  function automatic logic [1:0] rr_pick(input logic [1:0] elig, input logic pri);
    logic [1:0] grant;
    case (elig)
      2'b11:   grant = pri ? 2'b10 : 2'b01;
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

  logic [1:0]        wr_grant_s;
  logic [1:0]        rd_grant_s;
  logic [1:0]        rd_coll_s;
  logic [1:0]        rd_elig_s;
  logic              wr_xfer_s;
  logic              wr_idx_s;
  logic              rd_xfer_s;
  logic              rd_idx_s;
  logic [AWIDTH-1:0] wr_sel_addr_s;

  logic              wr_pri_r;
  logic              rd_pri_r;
  logic              rd_own1_r;   // owner of the read currently at the RAM port
  logic              rd_v2_r;     // RAM output register holds a requested word
  logic              rd_own2_r;   // owner of that word

  // Grant logic: writes arbitrate first; a reader hitting the address being
  // written this cycle drops out so it reads the new data on a later cycle.
  always_comb begin
    wr_grant_s    = 2'b00;
    rd_grant_s    = 2'b00;
    rd_coll_s     = 2'b00;
    rd_elig_s     = 2'b00;
    if (rst_n) begin
      wr_grant_s = rr_pick(wr_valid, wr_pri_r);
    end else begin
      wr_grant_s = 2'b00;
    end
    wr_xfer_s     = |wr_grant_s;
    wr_idx_s      = wr_grant_s[1];
    wr_sel_addr_s = wr_addr[wr_idx_s];
    for (int i = 0; i < 2; i++) begin
      rd_coll_s[i] = rd_valid[i] && wr_xfer_s && (rd_addr[i] == wr_sel_addr_s);
    end
    rd_elig_s = rd_valid & ~rd_coll_s;
    if (rst_n) begin
      rd_grant_s = rr_pick(rd_elig_s, rd_pri_r);
    end else begin
      rd_grant_s = 2'b00;
    end
    rd_xfer_s = |rd_grant_s;
    rd_idx_s  = rd_grant_s[1];
  end

  assign wr_ready = wr_grant_s;
  assign rd_ready = rd_grant_s;

  // Write side: pointer update and registered RAM write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_pri_r    <= 1'b0;
      ram_wenable <= 1'b0;
      ram_waddr   <= '0;
      ram_wdata   <= '0;
    end else begin
      ram_wenable <= wr_xfer_s;
      if (wr_xfer_s) begin
        wr_pri_r  <= ~wr_idx_s;
        ram_waddr <= wr_sel_addr_s;
        ram_wdata <= wr_data[wr_idx_s];
      end
    end
  end

  // Read side: pointer, RAM read port and the two-stage return pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pri_r    <= 1'b0;
      ram_renable <= 1'b0;
      ram_raddr   <= '0;
      rd_own1_r   <= 1'b0;
      rd_v2_r     <= 1'b0;
      rd_own2_r   <= 1'b0;
      rd_rvalid   <= 2'b00;
      rd_rdata    <= '0;
    end else begin
      ram_renable <= rd_xfer_s;
      if (rd_xfer_s) begin
        rd_pri_r  <= ~rd_idx_s;
        ram_raddr <= rd_addr[rd_idx_s];
        rd_own1_r <= rd_idx_s;
      end
      rd_v2_r   <= ram_renable;
      rd_own2_r <= rd_own1_r;
      if (rd_v2_r) begin
        rd_rvalid <= rd_own2_r ? 2'b10 : 2'b01;
        rd_rdata  <= ram_rdata;
      end else begin
        rd_rvalid <= 2'b00;
      end
    end
  end

  // Saturating count of cycles in which a reader lost only to a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= 16'h0000;
    end else if ((|rd_coll_s) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
